shift_seq_ctrl: RTL and testbench
=================================

SHIFT_SEQ_CTRL -- requirements
Module: shift_seq_ctrl

Interface
REQ-001 Parameter WIDTH, default 4: shift word width in bits, legal range 2..16.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  synchronous reset, active-low.
REQ-004 req  input  2  request per requester; bit i belongs to requester i.
REQ-005 din0  input  WIDTH  parallel word of requester 0; valid while req[0]=1.
REQ-006 din1  input  WIDTH  parallel word of requester 1; valid while req[1]=1.
REQ-007 gnt  output  2  one-hot, one-cycle grant pulse to the winning requester.
REQ-008 busy  output  1  high whenever the FSM is not in IDLE.
REQ-009 sout  output  1  serial data, MSB first.
REQ-010 sout_vld  output  1  high in every cycle that sout carries a valid bit.
REQ-011 done  output  1  one-cycle pulse when a transfer completes.
REQ-012 done_id  output  1  index of the requester whose transfer completed; meaningful only while done=1.

Function
REQ-013 The FSM SHALL have states IDLE, SHIFT, PAR (macro builds only) and DONE.
REQ-014 At an edge in IDLE with req!=0: load the winner's din into the internal WIDTH-bit shift register, clear the bit counter, register the winner, assert gnt[winner] for exactly the following cycle, and enter SHIFT.
REQ-015 Arbitration is round-robin: one requester -> that requester wins; both -> the requester not granted last wins.
REQ-016 In SHIFT: sout=shreg[WIDTH-1] and sout_vld=1; each edge shifts left with 0 fill and increments the counter; after WIDTH bits, go to PAR (macro) or DONE.
REQ-017 gnt and the first sout_vld cycle coincide; sout_vld is high for exactly WIDTH consecutive cycles (WIDTH+1 with macro).
REQ-018 In DONE: done=1, done_id=winner, sout_vld=0, then IDLE on the next edge.
REQ-019 No grant is issued in SHIFT, PAR or DONE; req changes there are ignored; dropping req mid-transfer does not abort it.
REQ-020 Minimum spacing between grants with continuous requests: WIDTH+2 cycles (WIDTH+3 with macro).
REQ-021 din is sampled only at the grant edge; later changes to din have no effect on the transfer in progress.
REQ-022 The bit counter width is ceil(log2(WIDTH+1)) and never wraps within a transfer.
REQ-023 sout=0 whenever sout_vld=0.

Reset
REQ-024 rst_n=0 at a rising edge: state=IDLE, shreg=0, counter=0, gnt=00, busy=0, sout=0, sout_vld=0, done=0, done_id=0.
REQ-025 The round-robin pointer resets to "last=1", so requester 0 wins the first contested arbitration.
REQ-026 Reset mid-transfer aborts the transfer with no done pulse; reset has priority over all other events in the same cycle.

Configuration
REQ-027 Macro SHIFT_SEQ_CTRL_PARITY_EN defined: after the WIDTH data bits, the PAR state drives one extra bit with sout_vld=1, equal to the XOR of the latched word (even parity).
REQ-028 Macro undefined: the PAR state and parity logic are absent, and SHIFT goes directly to DONE.

Verification
REQ-029 Reset: rst_n=0 for 2 cycles with req=11 -> all outputs 0 and no gnt during or in the first cycle after reset.
REQ-030 Single transfer: req=01, din0=1011 -> gnt=01 for one cycle; sout=1,0,1,1 with sout_vld=1 for 4 cycles; then done=1, done_id=0; busy=1 from grant through DONE.
REQ-031 Contention: req=11 held, din0=1100, din1=0011 -> grants in order 0, 1, 0; serial streams 1100, 0011, 1100; grants are 6 cycles apart (macro off).
REQ-032 Reset mid-shift: rst_n=0 at the edge after the 2nd bit of din0=1011 -> next cycle all outputs 0 and no done; then req=10 -> gnt=10.
REQ-033 Parity (macro on): din0=1011 -> serial 1,0,1,1,1 over 5 sout_vld cycles, then done; macro off -> done immediately after the 4th bit.
REQ-034 Request drop: req=01 deasserted and din0 changed in the 2nd SHIFT cycle -> the original word completes unchanged, with done=1 and done_id=0.

Source files
------------

// File: rtl/shift_seq_ctrl.sv
// rtl/shift_seq_ctrl.sv - two-requester round-robin arbiter with MSB-first serializer
// Optional even-parity trailer bit when SHIFT_SEQ_CTRL_PARITY_EN is defined.
module shift_seq_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req,
    input  logic [WIDTH-1:0] din0,
    input  logic [WIDTH-1:0] din1,
    output logic [1:0]       gnt,
    output logic             busy,
    output logic             sout,
    output logic             sout_vld,
    output logic             done,
    output logic             done_id
);

    localparam int CW = $clog2(WIDTH + 1);

`ifdef SHIFT_SEQ_CTRL_PARITY_EN
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_PAR, S_DONE} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;
`endif

    state_t           r_state;
    logic [WIDTH-1:0] r_shreg;
    logic [CW-1:0]    r_cnt;
    logic [1:0]       r_gnt;
    logic             r_id;
    logic             r_last;
`ifdef SHIFT_SEQ_CTRL_PARITY_EN
    logic             r_par;
`endif

    logic             w_win;
    logic [WIDTH-1:0] w_din;

    // On contention the requester that was not granted last wins.
    assign w_win = (req == 2'b11) ? ~r_last : req[1];
    assign w_din = w_win ? din1 : din0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_shreg <= '0;
            r_cnt   <= '0;
            r_gnt   <= 2'b00;
            r_id    <= 1'b0;
            r_last  <= 1'b1;
`ifdef SHIFT_SEQ_CTRL_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            r_gnt <= 2'b00;
            case (r_state)
                S_IDLE: begin
                    if (req != 2'b00) begin
                        r_shreg <= w_din;
                        r_cnt   <= '0;
                        r_id    <= w_win;
                        r_last  <= w_win;
                        r_gnt   <= w_win ? 2'b10 : 2'b01;
`ifdef SHIFT_SEQ_CTRL_PARITY_EN
                        r_par   <= ^w_din;
`endif
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_shreg <= {r_shreg[WIDTH-2:0], 1'b0};
                    r_cnt   <= r_cnt + CW'(1);
                    if (r_cnt == CW'(WIDTH - 1)) begin
`ifdef SHIFT_SEQ_CTRL_PARITY_EN
                        r_state <= S_PAR;
`else
                        r_state <= S_DONE;
`endif
                    end
                end
`ifdef SHIFT_SEQ_CTRL_PARITY_EN
                S_PAR:   r_state <= S_DONE;
`endif
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign gnt     = r_gnt;
    assign busy    = (r_state != S_IDLE);
    assign done    = (r_state == S_DONE);
    assign done_id = r_id;

`ifdef SHIFT_SEQ_CTRL_PARITY_EN
    assign sout_vld = (r_state == S_SHIFT) || (r_state == S_PAR);
    assign sout     = (r_state == S_SHIFT) ? r_shreg[WIDTH-1] :
                      (r_state == S_PAR)   ? r_par : 1'b0;
`else
    assign sout_vld = (r_state == S_SHIFT);
    assign sout     = (r_state == S_SHIFT) ? r_shreg[WIDTH-1] : 1'b0;
`endif

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb/tb_shift_seq_ctrl.sv - scoreboard bench for shift_seq_ctrl (WIDTH=4)
module tb_shift_seq_ctrl;

    localparam int WIDTH = 4;
`ifdef SHIFT_SEQ_CTRL_PARITY_EN
    localparam int NB    = WIDTH + 1;
    localparam int SPACE = WIDTH + 3;
`else
    localparam int NB    = WIDTH;
    localparam int SPACE = WIDTH + 2;
`endif

    typedef struct {
        int id;
        int word;
    } xfer_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [1:0]       req;
    logic [WIDTH-1:0] din0;
    logic [WIDTH-1:0] din1;
    logic [1:0]       gnt;
    logic             busy;
    logic             sout;
    logic             sout_vld;
    logic             done;
    logic             done_id;

    int    n_checks = 0;
    int    n_errors = 0;
    int    cyc = 0;
    int    n_gnt = 0;
    int    t_gnt [0:15];
    int    nb = 0;
    int    bits = 0;
    int    q_gnt [$];
    xfer_t q_xfer [$];

    shift_seq_ctrl #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .din0     (din0),
        .din1     (din1),
        .gnt      (gnt),
        .busy     (busy),
        .sout     (sout),
        .sout_vld (sout_vld),
        .done     (done),
        .done_id  (done_id)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    function automatic int exp_word(input logic [WIDTH-1:0] w);
`ifdef SHIFT_SEQ_CTRL_PARITY_EN
        return int'({w, ^w});
`else
        return int'(w);
`endif
    endfunction

    function automatic xfer_t mk(input int id, input logic [WIDTH-1:0] w);
        xfer_t x;
        x.id   = id;
        x.word = exp_word(w);
        return x;
    endfunction

    // Monitor: collects serial bits and compares against the scoreboard.
    always @(negedge clk) begin
        int    e;
        xfer_t x;
        if (!rst_n) begin
            nb   = 0;
            bits = 0;
        end else begin
            if (sout_vld) begin
                bits = (bits << 1) | int'(sout);
                nb++;
                check("busy_vld", busy, 1);
            end else begin
                check("sout_idle", sout, 0);
            end
            if (gnt != 2'b00) begin
                if (q_gnt.size() == 0) begin
                    check("gnt_unexp", gnt, 0);
                end else begin
                    e = q_gnt.pop_front();
                    check("gnt", gnt, 2'b01 << e);
                    check("gnt_vld", sout_vld, 1);
                end
                if (n_gnt < 16) t_gnt[n_gnt] = cyc;
                n_gnt++;
            end
            if (done) begin
                check("busy_done", busy, 1);
                check("done_vld", sout_vld, 0);
                if (q_xfer.size() == 0) begin
                    check("done_unexp", done, 0);
                end else begin
                    x = q_xfer.pop_front();
                    check("done_id", done_id, x.id);
                    check("nbits", nb, NB);
                    check("word", bits, x.word);
                end
                nb   = 0;
                bits = 0;
            end
        end
    end

    task automatic check_idle(input string tag);
        check({tag, "_gnt"}, gnt, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_sout"}, sout, 0);
        check({tag, "_vld"}, sout_vld, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_id"}, done_id, 0);
    endtask

    task automatic wait_gnt(input int target, input string tag);
        int k;
        for (k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (n_gnt >= target) break;
        end
        if (k == 40) check({tag, "_timeout"}, 1, 0);
    endtask

    task automatic wait_empty(input string tag);
        int k;
        for (k = 0; k < 60; k++) begin
            @(posedge clk); #1;
            if (q_xfer.size() == 0) break;
        end
        if (k == 60) check({tag, "_timeout"}, 1, 0);
    endtask

    // Single requester transfer; req and din change in the 2nd SHIFT cycle.
    task automatic xfer(input int id, input logic [WIDTH-1:0] w, input logic [WIDTH-1:0] w_after);
        int base;
        base = n_gnt;
        q_gnt.push_back(id);
        q_xfer.push_back(mk(id, w));
        if (id == 0) din0 = w; else din1 = w;
        req = (id == 0) ? 2'b01 : 2'b10;
        wait_gnt(base + 1, "xfer_gnt");
        req = 2'b00;
        if (id == 0) din0 = w_after; else din1 = w_after;
        wait_empty("xfer_done");
    endtask

    initial begin
        int base;
        rst_n = 1'b0;
        req   = 2'b11;
        din0  = 4'b1100;
        din1  = 4'b0011;

        // Reset with both requests held; arbitration then starts from requester 0.
        @(posedge clk); #1;
        check_idle("rst1");
        @(posedge clk); #1;
        check_idle("rst2");
        q_gnt.push_back(0); q_xfer.push_back(mk(0, 4'b1100));
        q_gnt.push_back(1); q_xfer.push_back(mk(1, 4'b0011));
        q_gnt.push_back(0); q_xfer.push_back(mk(0, 4'b1100));
        rst_n = 1'b1;
        wait_gnt(3, "cont_gnt");
        req = 2'b00;
        wait_empty("cont_done");
        check("space01", t_gnt[1] - t_gnt[0], SPACE);
        check("space12", t_gnt[2] - t_gnt[1], SPACE);

        xfer(0, 4'b1011, 4'b1011);
        xfer(0, 4'b0110, 4'b1111);
        xfer(1, 4'b1001, 4'b0000);

        // Reset in the cycle carrying the 2nd bit of 1011; no done may follow.
        base = n_gnt;
        q_gnt.push_back(0);
        din0 = 4'b1011;
        req  = 2'b01;
        wait_gnt(base + 1, "mid_gnt");
        rst_n = 1'b0;
        req   = 2'b00;
        @(posedge clk); #1;
        check_idle("mid_rst");
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_idle("mid_post");
        xfer(1, 4'b0101, 4'b1010);

        // Pointer now says requester 1 was last: a contested request goes to 0.
        base = n_gnt;
        q_gnt.push_back(0);
        q_xfer.push_back(mk(0, 4'b1110));
        din0 = 4'b1110;
        din1 = 4'b0001;
        req  = 2'b11;
        wait_gnt(base + 1, "rr_gnt");
        req = 2'b00;
        wait_empty("rr_done");

        repeat (3) @(posedge clk);
        #1;
        check("q_gnt_empty", q_gnt.size(), 0);
        check("q_xfer_empty", q_xfer.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
